servo_cmd_ramp: RTL

//  Converts angle commands (0..180 deg) into a servo pulse width in clk cycles.

---
 rtl/servo_cmd_ramp.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/servo_cmd_ramp.sv
// -----------------------------------------------------------------------------
// servo_cmd_ramp
//   Turns angle commands (0..ANGLE_MAX deg) into a servo pulse width, in clk
//   cycles, that feeds the duty input of the servo PWM stage. The pulse width
//   moves toward the commanded target once per servo frame, so the servo never
//   jumps. The frame counter runs at the PWM period, keeping duty updates
//   aligned to PWM frame boundaries.
//
// Build option:
//   SERVO_RAMP_EN defined   : duty_o moves at most RAMP_STEP per frame.
//   SERVO_RAMP_EN undefined : duty_o takes the full target at the next frame
//                             boundary (RAMP_STEP has no effect).
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-high
//   cmd_valid    angle command valid
//   cmd_angle    commanded angle, deg (values above ANGLE_MAX are clamped)
//   cmd_ready    block accepts a command this cycle
//   duty_o       current pulse width, cycles
//   frame_tick   1-cycle pulse on the last cycle of each frame
//   busy         duty_o differs from the target
//   range_err    sticky: an accepted angle exceeded ANGLE_MAX (cleared by rst)
//   dbg_state_o  current FSM state (IDLE=0, CALC=1, RAMP=2), for observation
//
// Handshake: a command transfers on a rising clk edge where cmd_valid and
// cmd_ready are both high; cmd_angle is captured on that edge. cmd_ready is
// registered and drops for exactly the one CALC cycle after each transfer.
// -----------------------------------------------------------------------------
module servo_cmd_ramp #(
  parameter int CLK_IN     = 50_000_000,
  parameter int FREQ_SERVO = 50,
  parameter int MIN_PULSE  = 50_000,
  parameter int MAX_PULSE  = 100_000,
  parameter int ANGLE_MAX  = 180,
  parameter int RAMP_STEP  = 2_500,
  parameter int DUTY_W     = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic [7:0]        cmd_angle,
  output logic              cmd_ready,
  output logic [DUTY_W-1:0] duty_o,
  output logic              frame_tick,
  output logic              busy,
  output logic              range_err,
  output logic [1:0]        dbg_state_o
);

  localparam int FRAME_CYCLES = CLK_IN / FREQ_SERVO;
  localparam int CNT_W        = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam int STEP_PER_DEG = (MAX_PULSE - MIN_PULSE) / ANGLE_MAX;
  localparam int CENTER       = MIN_PULSE + 90 * STEP_PER_DEG;

  localparam logic [CNT_W-1:0]  CNT_LAST    = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [DUTY_W-1:0] CENTER_D    = DUTY_W'(CENTER);
  localparam logic [7:0]        ANGLE_MAX_B = 8'(ANGLE_MAX);

  // Without the ramp the per-frame limit is the widest possible difference,
  // so every boundary lands exactly on the target through the same datapath.
`ifdef SERVO_RAMP_EN
  localparam logic [DUTY_W:0] STEP_LIM = (DUTY_W+1)'(RAMP_STEP);
`else
  localparam logic [DUTY_W:0] STEP_LIM = {(DUTY_W+1){1'b1}} | (DUTY_W+1)'(RAMP_STEP);
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_RAMP = 2'd2
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tick_q;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [DUTY_W-1:0] target_q, target_d;
  logic [7:0]        angle_q, angle_d;
  logic              ready_q;
  logic              err_q;
  logic              xfer;
  logic [DUTY_W:0]   dw, tw, diff;

  assign xfer    = cmd_valid && ready_q;
  assign angle_d = (cmd_angle > ANGLE_MAX_B) ? ANGLE_MAX_B : cmd_angle;

  // Largest angle times STEP_PER_DEG stays inside DUTY_W bits.
  assign target_d = DUTY_W'(MIN_PULSE) + DUTY_W'(angle_q) * DUTY_W'(STEP_PER_DEG);

  always_comb begin
    cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
  end

  // Slew toward the target in one extra bit so the difference cannot wrap;
  // the partial step is taken only when it stays short of the target.
  always_comb begin
    dw     = {1'b0, duty_q};
    tw     = {1'b0, target_q};
    diff   = '0;
    duty_d = duty_q;
    if (tw >= dw) begin
      diff   = tw - dw;
      duty_d = (diff <= STEP_LIM) ? target_q : DUTY_W'(dw + STEP_LIM);
    end else begin
      diff   = dw - tw;
      duty_d = (diff <= STEP_LIM) ? target_q : DUTY_W'(dw - STEP_LIM);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      tick_q   <= 1'b0;
      duty_q   <= CENTER_D;
      target_q <= CENTER_D;
      angle_q  <= 8'd90;
      ready_q  <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_d == CNT_LAST);

      // Uses target_q as it was before this edge, so a target written in the
      // same cycle (CALC) only takes effect from the following tick.
      if (tick_q) duty_q <= duty_d;

      if (xfer) begin
        angle_q <= angle_d;
        if (cmd_angle > ANGLE_MAX_B) err_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (xfer) begin
            state_q <= S_CALC;
            ready_q <= 1'b0;
          end
        end
        S_CALC: begin
          target_q <= target_d;
          state_q  <= S_RAMP;
          ready_q  <= 1'b1;
        end
        S_RAMP: begin
          // A new command restarts CALC; the latest angle wins.
          if (xfer) begin
            state_q <= S_CALC;
            ready_q <= 1'b0;
          end else if (duty_q == target_q) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready   = ready_q;
  assign duty_o      = duty_q;
  assign frame_tick  = tick_q;
  assign busy        = (duty_q != target_q);
  assign range_err   = err_q;
  assign dbg_state_o = state_q;

endmodule
